link_align_controller: RTL and testbench
========================================

Name: link_align_controller

Overview:
- Per-lane receive block-alignment controller for one transceiver rx lane.
- Inspects the sync bits of each received header and pulses rx_slip until the gearbox lands on the correct boundary.
- Declares lock after a run of consecutive good headers, and drops lock on an excessive bad-header rate.
- One instance per rx lane, alongside each Controller_Transceiver / Node_Transceiver rx port, in the rx_clock domain, which is wired to this block's clock port.

Parameters:
- LOCK_COUNT, 64, consecutive good headers required to declare lock.
- SLIP_WAIT, 32, cycles to ignore headers after each slip pulse (gearbox settle time).
- WINDOW, 1024, valid headers per bad-header monitoring window while locked.
- BAD_LIMIT, 16, bad headers within one window that cause loss of lock.

Ports:
- clock  input  1  lane rx clock.
- reset  input  1  asynchronous, active-high reset.
- activate  input  1  enables alignment; low forces IDLE.
- rx_header  input  [0:5]  received header; sync bits are rx_header[0:1].
- rx_header_valid  input  1  rx_header is meaningful this cycle.
- rx_slip  output  1  one-cycle slip request to the transceiver.
- locked  output  1  lane aligned.
- slip_count  output  [0:15]  slips issued since activation, saturating.

Behaviour:
- Good header: rx_header_valid=1 and rx_header[0:1] is 01 or 10. Bad header: rx_header_valid=1 and rx_header[0:1] is 00 or 11. Cycles with rx_header_valid=0 are ignored in every state.
- Reset (async): state IDLE; rx_slip=0; locked=0; slip_count=0; all internal counters 0.
- All outputs are registered. Counter widths are log2 of the respective parameter plus 1.
- States: IDLE, HUNT, SLIP, WAIT, LOCKED.
- IDLE: outputs 0; slip_count cleared. If activate=1, go to HUNT next cycle with good_cnt=0.
- activate=0 in any state: go to IDLE next cycle. locked, rx_slip and slip_count go to 0 on that edge. This overrides every other transition.
- HUNT, good header:
  - good_cnt increments.
  - If this is the LOCK_COUNT-th consecutive good header, go to LOCKED; locked=1 from the next cycle.
- HUNT, bad header: good_cnt=0; go to SLIP.
- SLIP: lasts exactly 1 cycle.
  - rx_slip=1 for exactly that cycle, i.e. the cycle after the bad header was sampled.
  - slip_count increments, saturating at 65535.
  - Then go to WAIT.
- WAIT: wait_cnt counts SLIP_WAIT cycles with headers ignored, then go to HUNT with good_cnt=0. The first HUNT cycle is SLIP_WAIT+1 cycles after the rx_slip cycle.
- LOCKED: locked=1. hdr_cnt counts valid headers; bad_cnt counts bad headers.
  - If bad_cnt reaches BAD_LIMIT, go to HUNT: locked=0 next cycle, all counters cleared. No slip is issued on loss of lock; HUNT decides.
  - When hdr_cnt reaches WINDOW, clear hdr_cnt and bad_cnt.
  - Simultaneous event: if the WINDOW-th header is also the BAD_LIMIT-th bad header, loss of lock wins.
- rx_slip is never high for two consecutive cycles. Minimum spacing between slip pulses is SLIP_WAIT+2 cycles.
- Reset asserted mid-slip: rx_slip drops immediately (async).

Test Plan:
(Small parameters: LOCK_COUNT=4, SLIP_WAIT=3, WINDOW=8, BAD_LIMIT=2.)
- Reset, activate=1, continuous headers 01 -> locked rises the cycle after the 4th valid header; rx_slip never asserted; slip_count=0.
- In HUNT, headers 00 -> rx_slip high exactly 1 cycle, then 3 ignored cycles, then HUNT. With 00 persisting, the pulse repeats every 5 cycles and slip_count counts 1, 2, 3.
- In HUNT, 3 good headers then 11 -> good_cnt resets and a slip is issued. Then 4 good headers -> lock; slip_count=1.
- While locked, 1 bad header in each of three 8-header windows -> locked stays 1. Two bad headers within one window -> locked=0 the next cycle, state HUNT, no rx_slip pulse.
- While locked, 7 good headers, then the 8th header is bad with bad_cnt=1 already -> lock lost (priority over window clear).
- activate dropped during WAIT with slip_count=2 -> next cycle state IDLE, slip_count=0, rx_slip=0. Reset asserted during SLIP -> rx_slip=0 asynchronously.

Source files
------------

// File: rtl/link_align_controller_if.sv
// ----------------------------------------------------------------------------
// link_align_controller_if
//
// Groups the lane-side signals of the rx block-alignment controller.
//
//   activate         transceiver side -> controller : enable alignment
//   rx_header[0:5]   transceiver side -> controller : received block header,
//                                                     sync bits are [0:1]
//   rx_header_valid  transceiver side -> controller : rx_header meaningful
//   rx_slip          controller -> transceiver side : one-cycle slip request
//   locked           controller -> transceiver side : lane aligned
//   slip_count[0:15] controller -> transceiver side : slips since activation
//   state_dbg[2:0]   controller -> observer         : FSM state
//                    (0 IDLE, 1 HUNT, 2 SLIP, 3 WAIT, 4 LOCKED)
//
// Handshake: there is no backpressure. A header is consumed on every rising
// clock edge at which rx_header_valid is high; cycles with rx_header_valid
// low carry no header. rx_slip is a single-cycle request with no acknowledge.
//
// master : transceiver / stimulus side.   slave : the controller.
// ----------------------------------------------------------------------------
interface link_align_controller_if;
    logic        activate;
    logic [0:5]  rx_header;
    logic        rx_header_valid;
    logic        rx_slip;
    logic        locked;
    logic [0:15] slip_count;
    logic [2:0]  state_dbg;

    modport master (
        output activate,
        output rx_header,
        output rx_header_valid,
        input  rx_slip,
        input  locked,
        input  slip_count,
        input  state_dbg
    );

    modport slave (
        input  activate,
        input  rx_header,
        input  rx_header_valid,
        output rx_slip,
        output locked,
        output slip_count,
        output state_dbg
    );
endinterface

// File: rtl/link_align_controller.sv
// ----------------------------------------------------------------------------
// link_align_controller
//
// Per-lane receive block-alignment controller. Watches the two sync bits of
// each received header, pulses rx_slip to the transceiver gearbox until the
// block boundary is found, declares lock after LOCK_COUNT consecutive good
// headers and drops lock when BAD_LIMIT bad headers are seen within one
// WINDOW of valid headers.
//
// Ports:
//   clock  lane rx clock
//   reset  asynchronous, active-high reset
//   bus    link_align_controller_if.slave
//            in : activate, rx_header[0:5], rx_header_valid
//            out: rx_slip, locked, slip_count[0:15], state_dbg[2:0]
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module link_align_controller #(
    parameter int LOCK_COUNT = 64,
    parameter int SLIP_WAIT  = 32,
    parameter int WINDOW     = 1024,
    parameter int BAD_LIMIT  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    link_align_controller_if.slave  bus
);

    localparam int GW = $clog2(LOCK_COUNT) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;
    localparam int HW = $clog2(WINDOW) + 1;
    localparam int BW = $clog2(BAD_LIMIT) + 1;

    // Counter values at which the *current* event is the terminal one.
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
    localparam logic [HW-1:0] HDR_LAST  = HW'(WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   good_cnt_q;
    logic [WW-1:0]   wait_cnt_q;
    logic [HW-1:0]   hdr_cnt_q;
    logic [BW-1:0]   bad_cnt_q;
    logic            rx_slip_q;
    logic            locked_q;
    logic [0:15]     slip_count_q;

    logic [1:0]      sync;
    logic            hdr_good;
    logic            hdr_bad;
    logic [0:15]     slip_count_d;

    // Sync field 01/10 marks a block boundary; 00/11 cannot occur on a
    // correctly aligned lane.
    always_comb begin
        sync         = bus.rx_header[0:1];
        hdr_good     = bus.rx_header_valid & (sync[1] ^ sync[0]);
        hdr_bad      = bus.rx_header_valid & ~(sync[1] ^ sync[0]);
        slip_count_d = (slip_count_q == 16'hFFFF) ? slip_count_q
                                                  : slip_count_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            good_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            hdr_cnt_q    <= '0;
            bad_cnt_q    <= '0;
            rx_slip_q    <= 1'b0;
            locked_q     <= 1'b0;
            slip_count_q <= '0;
        end else if (!bus.activate) begin
            // Deactivation overrides every other transition.
            state_q      <= ST_IDLE;
            good_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            hdr_cnt_q    <= '0;
            bad_cnt_q    <= '0;
            rx_slip_q    <= 1'b0;
            locked_q     <= 1'b0;
            slip_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q      <= ST_HUNT;
                    good_cnt_q   <= '0;
                    rx_slip_q    <= 1'b0;
                    locked_q     <= 1'b0;
                    slip_count_q <= '0;
                end

                ST_HUNT: begin
                    if (hdr_good) begin
                        if (good_cnt_q == GOOD_LAST) begin
                            state_q    <= ST_LOCKED;
                            locked_q   <= 1'b1;
                            good_cnt_q <= '0;
                            hdr_cnt_q  <= '0;
                            bad_cnt_q  <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 1'b1;
                        end
                    end else if (hdr_bad) begin
                        // rx_slip is raised on entry so it is high for
                        // exactly the SLIP cycle.
                        state_q      <= ST_SLIP;
                        good_cnt_q   <= '0;
                        rx_slip_q    <= 1'b1;
                        slip_count_q <= slip_count_d;
                    end
                end

                ST_SLIP: begin
                    state_q    <= ST_WAIT;
                    rx_slip_q  <= 1'b0;
                    wait_cnt_q <= '0;
                end

                ST_WAIT: begin
                    // Headers are ignored while the gearbox settles.
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= ST_HUNT;
                        wait_cnt_q <= '0;
                        good_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (bus.rx_header_valid) begin
                        // Loss of lock is tested first so it beats the
                        // window wrap on the same header.
                        if (hdr_bad && (bad_cnt_q == BAD_LAST)) begin
                            state_q    <= ST_HUNT;
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                            hdr_cnt_q  <= '0;
                            bad_cnt_q  <= '0;
                        end else if (hdr_cnt_q == HDR_LAST) begin
                            hdr_cnt_q <= '0;
                            bad_cnt_q <= '0;
                        end else begin
                            hdr_cnt_q <= hdr_cnt_q + 1'b1;
                            if (hdr_bad) begin
                                bad_cnt_q <= bad_cnt_q + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    rx_slip_q <= 1'b0;
                    locked_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_slip    = rx_slip_q;
    assign bus.locked     = locked_q;
    assign bus.slip_count = slip_count_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_link_align_controller.sv
// ----------------------------------------------------------------------------
// tb_link_align_controller
//
// Drives one controller instance with small parameters through directed
// scenarios followed by a randomized run, comparing every cycle against a
// behavioural model of the alignment rules.
// ----------------------------------------------------------------------------
module tb_link_align_controller;

    localparam int LOCK_COUNT = 4;
    localparam int SLIP_WAIT  = 3;
    localparam int WINDOW     = 8;
    localparam int BAD_LIMIT  = 2;

    // Observable state codes (documented in the interface header).
    localparam int S_IDLE   = 0;
    localparam int S_HUNT   = 1;
    localparam int S_SLIP   = 2;
    localparam int S_WAIT   = 3;
    localparam int S_LOCKED = 4;

    localparam logic [0:5] H_GOOD01 = 6'b01_0000;
    localparam logic [0:5] H_GOOD10 = 6'b10_1010;
    localparam logic [0:5] H_BAD00  = 6'b00_0101;
    localparam logic [0:5] H_BAD11  = 6'b11_0011;

    logic clock;
    logic reset;

    link_align_controller_if bus ();

    link_align_controller #(
        .LOCK_COUNT (LOCK_COUNT),
        .SLIP_WAIT  (SLIP_WAIT),
        .WINDOW     (WINDOW),
        .BAD_LIMIT  (BAD_LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard counters ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic prev_slip = 1'b0;

    // ---------------- reference model ----------------
    // Alignment is described by: active or not, locked or not, a "blind"
    // countdown covering the slip cycle plus the settle time, a run length
    // of good headers, per-window header/bad tallies and the slip total.
    bit m_active;
    bit m_locked;
    bit m_slip;
    int m_blind;
    int m_good;
    int m_hdrs;
    int m_bads;
    int m_slips;

    task automatic model_reset();
        m_active = 0;
        m_locked = 0;
        m_slip   = 0;
        m_blind  = 0;
        m_good   = 0;
        m_hdrs   = 0;
        m_bads   = 0;
        m_slips  = 0;
    endtask

    task automatic model_step(input logic act, input logic v, input logic [0:5] h);
        logic [1:0] s;
        bit is_good;
        bit is_bad;
        s       = h[0:1];
        is_good = v && (s == 2'b01 || s == 2'b10);
        is_bad  = v && (s == 2'b00 || s == 2'b11);
        if (!act) begin
            model_reset();
        end else if (!m_active) begin
            m_active = 1;
            m_good   = 0;
        end else if (m_blind > 0) begin
            m_blind = m_blind - 1;
            m_slip  = 0;
        end else if (m_locked) begin
            if (v) begin
                m_hdrs = m_hdrs + 1;
                if (is_bad) m_bads = m_bads + 1;
                if (m_bads >= BAD_LIMIT) begin
                    m_locked = 0;
                    m_hdrs   = 0;
                    m_bads   = 0;
                    m_good   = 0;
                end else if (m_hdrs == WINDOW) begin
                    m_hdrs = 0;
                    m_bads = 0;
                end
            end
        end else begin
            if (is_good) begin
                m_good = m_good + 1;
                if (m_good == LOCK_COUNT) begin
                    m_locked = 1;
                    m_good   = 0;
                    m_hdrs   = 0;
                    m_bads   = 0;
                end
            end else if (is_bad) begin
                m_good  = 0;
                m_slip  = 1;
                m_slips = (m_slips < 65535) ? m_slips + 1 : 65535;
                m_blind = SLIP_WAIT + 1;
            end
        end
    endtask

    function automatic int model_state();
        if (!m_active)     return S_IDLE;
        if (m_slip)        return S_SLIP;
        if (m_blind > 0)   return S_WAIT;
        if (m_locked)      return S_LOCKED;
        return S_HUNT;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("rx_slip",    16'(bus.rx_slip),    16'(m_slip));
        check("locked",     16'(bus.locked),     16'(m_locked));
        check("slip_count", 16'(bus.slip_count), 16'(m_slips));
        check("state",      16'(bus.state_dbg),  16'(model_state()));
        check("slip_back_to_back", 16'(prev_slip & bus.rx_slip), 16'd0);
        prev_slip = bus.rx_slip;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic act, input logic v, input logic [0:5] h);
        bus.activate        = act;
        bus.rx_header_valid = v;
        bus.rx_header       = h;
        @(posedge clock);
        model_step(act, v, h);
        #1;
        check_model();
    endtask

    function automatic logic [0:5] rand_header(input int bad_pct);
        logic [1:0] s;
        logic [3:0] pay;
        pay = 4'($urandom);
        if (int'($urandom_range(0, 99)) < bad_pct)
            s = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        else
            s = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        return {s, pay};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.activate        = 1'b0;
        bus.rx_header_valid = 1'b0;
        bus.rx_header       = '0;
        reset = 1'b1;
        model_reset();
        #12;
        check("reset_rx_slip",    16'(bus.rx_slip),    16'd0);
        check("reset_locked",     16'(bus.locked),     16'd0);
        check("reset_slip_count", 16'(bus.slip_count), 16'd0);
        check("reset_state",      16'(bus.state_dbg),  16'(S_IDLE));
        @(negedge clock);
        reset = 1'b0;

        // Continuous good headers: lock after the 4th, no slips.
        cycle(1'b1, 1'b1, H_GOOD01);                 // IDLE -> HUNT
        for (int i = 0; i < LOCK_COUNT - 1; i++) begin
            cycle(1'b1, 1'b1, H_GOOD01);
            check("lock_not_early", 16'(bus.locked), 16'd0);
        end
        cycle(1'b1, 1'b1, H_GOOD01);
        check("lock_after_4", 16'(bus.locked), 16'd1);
        check("lock_no_slips", 16'(bus.slip_count), 16'd0);

        // Persistent 00 headers: a slip every SLIP_WAIT+2 cycles.
        cycle(1'b0, 1'b0, H_GOOD01);
        cycle(1'b1, 1'b1, H_BAD00);                  // IDLE -> HUNT
        for (int i = 0; i < 3 * (SLIP_WAIT + 2) - SLIP_WAIT - 1; i++)
            cycle(1'b1, 1'b1, H_BAD00);
        check("third_slip_pulse", 16'(bus.rx_slip), 16'd1);
        check("third_slip_count", 16'(bus.slip_count), 16'd3);

        // 3 good then 11, ignored bad headers during settle, then lock.
        cycle(1'b0, 1'b0, H_GOOD01);
        cycle(1'b1, 1'b1, H_GOOD10);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, H_GOOD10);
        cycle(1'b1, 1'b1, H_BAD11);
        check("slip_after_run", 16'(bus.rx_slip), 16'd1);
        for (int i = 0; i < SLIP_WAIT + 1; i++) cycle(1'b1, 1'b1, H_BAD00);
        check("settle_ignores_bad", 16'(bus.slip_count), 16'd1);
        for (int i = 0; i < LOCK_COUNT; i++) cycle(1'b1, 1'b1, H_GOOD01);
        check("relock", 16'(bus.locked), 16'd1);
        check("relock_slip_count", 16'(bus.slip_count), 16'd1);

        // One bad header per window for three windows keeps lock.
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < WINDOW; i++)
                cycle(1'b1, 1'b1, (i == 3) ? H_BAD00 : H_GOOD01);
        check("windows_keep_lock", 16'(bus.locked), 16'd1);
        // Two bad headers in one window lose lock without a slip.
        cycle(1'b1, 1'b1, H_GOOD01);
        cycle(1'b1, 1'b1, H_BAD00);
        cycle(1'b1, 1'b1, H_BAD11);
        check("lock_lost", 16'(bus.locked), 16'd0);
        check("lock_lost_state", 16'(bus.state_dbg), 16'(S_HUNT));
        check("lock_lost_no_slip", 16'(bus.rx_slip), 16'd0);
        cycle(1'b1, 1'b0, H_BAD00);                  // invalid header ignored
        check("invalid_ignored", 16'(bus.rx_slip), 16'd0);

        // Window-end header that is also the BAD_LIMIT-th bad: lock lost.
        for (int i = 0; i < LOCK_COUNT; i++) cycle(1'b1, 1'b1, H_GOOD10);
        cycle(1'b1, 1'b1, H_BAD00);
        for (int i = 0; i < WINDOW - 2; i++) cycle(1'b1, 1'b1, H_GOOD10);
        check("pre_window_end", 16'(bus.locked), 16'd1);
        cycle(1'b1, 1'b1, H_BAD11);
        check("window_end_loss", 16'(bus.locked), 16'd0);

        // Deactivate during WAIT with slip_count = 2.
        cycle(1'b1, 1'b1, H_BAD00);
        check("second_slip_count", 16'(bus.slip_count), 16'd2);
        cycle(1'b1, 1'b1, H_GOOD01);
        check("in_wait", 16'(bus.state_dbg), 16'(S_WAIT));
        cycle(1'b0, 1'b1, H_GOOD01);
        check("deact_state", 16'(bus.state_dbg), 16'(S_IDLE));
        check("deact_slip_count", 16'(bus.slip_count), 16'd0);
        check("deact_rx_slip", 16'(bus.rx_slip), 16'd0);

        // Asynchronous reset in the middle of a slip pulse.
        cycle(1'b1, 1'b1, H_GOOD01);
        cycle(1'b1, 1'b1, H_BAD11);
        check("pre_reset_slip", 16'(bus.rx_slip), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_slip", 16'(bus.rx_slip), 16'd0);
        check("async_reset_count", 16'(bus.slip_count), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        prev_slip = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic act;
            logic v;
            int   bad_pct;
            act     = ($urandom_range(0, 199) != 0);
            v       = ($urandom_range(0, 9) != 0);
            bad_pct = (i % 600 < 300) ? 4 : 30;
            cycle(act, v, rand_header(bad_pct));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
